// File: rtl/melay_overlapping_if.sv
// Serial bit-stream bus for the 1011 sequence detector.
// Signals: x (serial data bit into detector), z (Mealy match flag out).
interface melay_overlapping_if;
  logic x;
  logic z;

  modport master (
    output x,
    input  z
  );

  modport slave (
    input  x,
    output z
  );
endinterface

// File: rtl/melay_overlapping.sv
// Mealy detector for serial pattern 1011, overlapping matches allowed.
// Ports: clk, reset (sync, active-high), bus.x (data in), bus.z (match).
module melay_overlapping (
  input  logic                clk,
  input  logic                reset,
  melay_overlapping_if.slave  bus
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t state;
  state_t nxt;
  logic   hit;

  always_ff @(posedge clk) begin
    if (reset) state <= S0;
    else       state <= nxt;
  end

  always_comb begin
    nxt = S0;
    hit = 1'b0;
    unique case (state)
      S0: nxt = bus.x ? S1 : S0;
      S1: nxt = bus.x ? S1 : S2;
      S2: nxt = bus.x ? S3 : S0;
      S3: begin
        // A "0" keeps the "10" suffix; a "1" completes
        // the match and doubles as the next prefix.
        nxt = bus.x ? S1 : S2;
        hit = bus.x;
      end
      default: nxt = S0;
    endcase
  end

  // Reset masks the flag even when the state still holds S3.
  assign bus.z = hit & ~reset;

endmodule

// File: tb/tb_melay_overlapping.sv
// Directed bench for the 1011 overlapping Mealy detector.
// Each scenario task drives x at negedge and checks z 1ns later.
module tb_melay_overlapping;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  melay_overlapping_if bus ();

  melay_overlapping dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.x = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [0:2] pre;
    pre = 3'b101;
    do_reset();
    // Walk into S3 so the reset mask on z is exercised.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.x = pre[i];
      #1;
    end
    @(negedge clk);
    reset = 1'b1;
    bus.x = 1'b1;
    #1;
    checks++;
    if (bus.z !== 1'b0) begin
      errors++;
      $display("FAIL reset_mask0 z=%b exp=0", bus.z);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'b00) begin
      errors++;
      $display("FAIL reset_state state=%0d exp=0", dut.state);
    end
    @(negedge clk);
    bus.x = 1'b0;
    #1;
    checks++;
    if (bus.z !== 1'b0) begin
      errors++;
      $display("FAIL reset_mask1 z=%b exp=0", bus.z);
    end
    @(negedge clk);
    bus.x = 1'b1;
    #1;
    checks++;
    if (bus.z !== 1'b0) begin
      errors++;
      $display("FAIL reset_mask2 z=%b exp=0", bus.z);
    end
    reset = 1'b0;
  endtask

  task automatic test_reference();
    logic [0:15] v;
    logic [0:15] e;
    v = 16'b0010110110010110;
    e = 16'b0000010010000010;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.x = v[i];
      #1;
      checks++;
      if (bus.z !== e[i]) begin
        errors++;
        $display("FAIL reference[%0d] z=%b exp=%b", i, bus.z, e[i]);
      end
    end
  endtask

  task automatic test_nonmatch();
    logic [0:13] v;
    logic [0:13] e;
    v = 14'b11100100101011;
    e = 14'b00000000000001;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.x = v[i];
      #1;
      checks++;
      if (bus.z !== e[i]) begin
        errors++;
        $display("FAIL nonmatch[%0d] z=%b exp=%b", i, bus.z, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:9] v;
    logic [0:9] e;
    v = 10'b1011011011;
    e = 10'b0001001001;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.x = v[i];
      #1;
      checks++;
      if (bus.z !== e[i]) begin
        errors++;
        $display("FAIL b2b[%0d] z=%b exp=%b", i, bus.z, e[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [0:2] a;
    logic [0:3] b;
    logic [0:3] e;
    a = 3'b101;
    b = 4'b1011;
    e = 4'b0001;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.x = a[i];
      #1;
      checks++;
      if (bus.z !== 1'b0) begin
        errors++;
        $display("FAIL midrst_pre[%0d] z=%b exp=0", i, bus.z);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    bus.x = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      bus.x = b[i];
      #1;
      checks++;
      if (bus.z !== e[i]) begin
        errors++;
        $display("FAIL midrst_post[%0d] z=%b exp=%b", i, bus.z, e[i]);
      end
    end
  endtask

  task automatic test_constant();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        bus.x = (k == 1);
        #1;
        checks++;
        if (bus.z !== 1'b0) begin
          errors++;
          $display("FAIL const%0d[%0d] z=%b exp=0", k, i, bus.z);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.x  = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_reference();
    test_nonmatch();
    test_back_to_back();
    test_mid_reset();
    test_constant();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
